// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_pc_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Fetch side: issues requests, receives the acknowledged word.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns the word with ack.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: RV32I program counter and instruction-fetch stage.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned next PC;
// when undefined, next_pc[1:0] is forced to 00 and misalign_o is tied low).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_pc_unit_if.master imem,
    input  logic            branch_taken_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic [31:0]     imm_i,
    input  logic [31:0]     rs1_val_i,
    input  logic            instr_done_i,
    output logic [31:0]     instr_o,
    output logic            instr_valid_o,
    output logic [31:0]     pc_o,
    output logic [31:0]     pc_plus4_o,
    output logic            misalign_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_TRAP} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_e;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;
    logic [XLEN-1:0] next_pc_c;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misalign_q, misalign_d;
`endif

    // Next-PC selection: JALR > JAL > taken branch > fall-through, all mod 2^32.
    always_comb begin
        logic [XLEN-1:0] target;
        target = XLEN'(pc_q + 32'd4);
        if (is_jalr_i) begin
            target = XLEN'(rs1_val_i + imm_i) & ~32'h1;
        end else if (is_jal_i) begin
            target = XLEN'(pc_q + imm_i);
        end else if (is_branch_i && branch_taken_i) begin
            target = XLEN'(pc_q + imm_i);
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        next_pc_c = target;
`else
        next_pc_c = {target[XLEN-1:2], 2'b00};
`endif
    end

    // State register; reset abandons any outstanding request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            pc_plus4_q    <= XLEN'(RESET_PC + 32'd4);
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    // Next-state and registered-output logic for the fetch sequence.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_plus4_d    = pc_plus4_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d    = misalign_q;
`endif
        case (state_q)
            S_IDLE: begin
                state_d       = S_REQ;
                imem_req_d    = 1'b1;
                imem_addr_d   = pc_q;
                instr_valid_d = 1'b0;
            end
            S_REQ: begin
                if (imem.imem_ack) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_done_i) begin
                    instr_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (next_pc_c[1:0] != 2'b00) begin
                        // PC stays on the faulting instruction; no further fetch.
                        misalign_d = 1'b1;
                        imem_req_d = 1'b0;
                        state_d    = S_TRAP;
                    end else
`endif
                    begin
                        pc_d        = next_pc_c;
                        pc_plus4_d  = XLEN'(next_pc_c + 32'd4);
                        imem_addr_d = next_pc_c;
                        imem_req_d  = 1'b1;
                        state_d     = S_REQ;
                    end
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                misalign_d    = 1'b1;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d    = S_IDLE;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Output drive from registers.
    assign imem.imem_req   = imem_req_q;
    assign imem.imem_addr  = imem_addr_q;
    assign instr_o         = instr_q;
    assign instr_valid_o   = instr_valid_q;
    assign pc_o            = pc_q;
    assign pc_plus4_o      = pc_plus4_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_o      = misalign_q;
`else
    assign misalign_o      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed testbench for fetch_pc_unit with RESET_PC = 32'h100.
module tb_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken, is_branch, is_jal, is_jalr, instr_done;
    logic [31:0] imm, rs1_val;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, misalign;
    int          checks = 0;
    int          errors = 0;

    fetch_pc_unit_if imem_if();

    fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_if),
        .branch_taken_i (branch_taken),
        .is_branch_i    (is_branch),
        .is_jal_i       (is_jal),
        .is_jalr_i      (is_jalr),
        .imm_i          (imm),
        .rs1_val_i      (rs1_val),
        .instr_done_i   (instr_done),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .pc_o           (pc),
        .pc_plus4_o     (pc_plus4),
        .misalign_o     (misalign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait memory response for the current REQ cycle.
    task automatic mem_ack(input logic [31:0] data);
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = data;
        tick();
        imem_if.imem_ack   = 1'b0;
    endtask

    // Present decoder/branch inputs and pulse instr_done for one edge.
    task automatic retire(input logic jr, input logic j, input logic br, input logic tk,
                          input logic [31:0] im, input logic [31:0] rs);
        is_jalr = jr; is_jal = j; is_branch = br; branch_taken = tk;
        imm = im; rs1_val = rs; instr_done = 1'b1;
        tick();
        instr_done = 1'b0; is_jalr = 1'b0; is_jal = 1'b0; is_branch = 1'b0;
        branch_taken = 1'b0; imm = 32'h0; rs1_val = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_if.imem_ack = 1'b0; imem_if.imem_rdata = 32'h0;
        branch_taken = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        imm = 32'h0; rs1_val = 32'h0; instr_done = 1'b0;
        tick(); tick();
        checks++;
        if ({imem_if.imem_req, imem_if.imem_addr, pc, pc_plus4} !== {1'b0, 32'h100, 32'h100, 32'h104}) begin
            errors++;
            $display("FAIL reset_pc: got req=%b addr=%h pc=%h pc4=%h exp 0/00000100/00000100/00000104",
                     imem_if.imem_req, imem_if.imem_addr, pc, pc_plus4);
        end
        checks++;
        if ({instr, instr_valid, misalign} !== {32'h13, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_instr: got instr=%h valid=%b mis=%b exp 00000013/0/0", instr, instr_valid, misalign);
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (imem_if.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_req: got %b exp 0", imem_if.imem_req);
        end
        tick();
        checks++;
        if ({imem_if.imem_req, imem_if.imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h valid=%b exp 1/00000100/0",
                     imem_if.imem_req, imem_if.imem_addr, instr_valid);
        end
        mem_ack(32'h0000_0013);
        checks++;
        if ({instr_valid, instr, pc, pc_plus4, imem_if.imem_req} !== {1'b1, 32'h13, 32'h100, 32'h104, 1'b0}) begin
            errors++;
            $display("FAIL zero_wait_hold: got valid=%b instr=%h pc=%h pc4=%h req=%b exp 1/00000013/00000100/00000104/0",
                     instr_valid, instr, pc, pc_plus4, imem_if.imem_req);
        end
    endtask

    task automatic test_ignored_inputs();
        // Flags without instr_done in HOLD must not move the PC.
        is_jal = 1'b1; imm = 32'h1234;
        tick();
        is_jal = 1'b0; imm = 32'h0;
        checks++;
        if ({pc, instr_valid} !== {32'h100, 1'b1}) begin
            errors++;
            $display("FAIL hold_no_done: got pc=%h valid=%b exp 00000100/1", pc, instr_valid);
        end
        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({imem_if.imem_req, imem_if.imem_addr, pc, pc_plus4, instr_valid} !== {1'b1, 32'h104, 32'h104, 32'h108, 1'b0}) begin
            errors++;
            $display("FAIL fallthrough: got req=%b addr=%h pc=%h pc4=%h valid=%b exp 1/00000104/00000104/00000108/0",
                     imem_if.imem_req, imem_if.imem_addr, pc, pc_plus4, instr_valid);
        end
        // instr_done in REQ is ignored.
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        checks++;
        if ({imem_if.imem_req, pc, instr_valid} !== {1'b1, 32'h104, 1'b0}) begin
            errors++;
            $display("FAIL done_in_req: got req=%b pc=%h valid=%b exp 1/00000104/0", imem_if.imem_req, pc, instr_valid);
        end
        mem_ack(32'hDEAD_BEEF);
        checks++;
        if ({instr, instr_valid} !== {32'hDEAD_BEEF, 1'b1}) begin
            errors++;
            $display("FAIL fetch_data: got instr=%h valid=%b exp deadbeef/1", instr, instr_valid);
        end
    endtask

    task automatic test_wait_states();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({imem_if.imem_req, imem_if.imem_addr, instr_valid} !== {1'b1, 32'h100, 1'b0}) begin
                errors++;
                $display("FAIL wait_req%0d: got req=%b addr=%h valid=%b exp 1/00000100/0",
                         i, imem_if.imem_req, imem_if.imem_addr, instr_valid);
            end
            if (i == 3) begin
                imem_if.imem_ack = 1'b1;
                imem_if.imem_rdata = 32'h0040_0093;
            end
            tick();
        end
        imem_if.imem_ack = 1'b0;
        checks++;
        if ({instr_valid, instr, pc} !== {1'b1, 32'h0040_0093, 32'h100}) begin
            errors++;
            $display("FAIL wait_ack: got valid=%b instr=%h pc=%h exp 1/00400093/00000100", instr_valid, instr, pc);
        end
    endtask

    task automatic test_branch();
        retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        checks++;
        if ({imem_if.imem_addr, pc} !== {32'h200, 32'h200}) begin
            errors++;
            $display("FAIL jal_to_200: got addr=%h pc=%h exp 00000200", imem_if.imem_addr, pc);
        end
        mem_ack(32'h13);
        retire(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0);
        checks++;
        if ({imem_if.imem_addr, pc, pc_plus4} !== {32'h1F0, 32'h1F0, 32'h1F4}) begin
            errors++;
            $display("FAIL branch_taken: got addr=%h pc=%h pc4=%h exp 000001f0/000001f0/000001f4",
                     imem_if.imem_addr, pc, pc_plus4);
        end
        mem_ack(32'h13);
        retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        mem_ack(32'h13);
        retire(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0);
        checks++;
        if (imem_if.imem_addr !== 32'h204) begin
            errors++;
            $display("FAIL branch_not_taken: got addr=%h exp 00000204", imem_if.imem_addr);
        end
        mem_ack(32'h13);
        // branch_taken without is_branch is a fall-through.
        retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
        checks++;
        if (imem_if.imem_addr !== 32'h208) begin
            errors++;
            $display("FAIL taken_no_branch: got addr=%h exp 00000208", imem_if.imem_addr);
        end
        mem_ack(32'h13);
    endtask

    task automatic test_jalr_and_wrap();
        retire(1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'h1001);
        checks++;
        if ({imem_if.imem_addr, pc} !== {32'h1004, 32'h1004}) begin
            errors++;
            $display("FAIL jalr_priority: got addr=%h pc=%h exp 00001004", imem_if.imem_addr, pc);
        end
        mem_ack(32'h13);
        retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        checks++;
        if ({pc, pc_plus4} !== {32'hFFFF_FFFC, 32'h0}) begin
            errors++;
            $display("FAIL pc_top: got pc=%h pc4=%h exp fffffffc/00000000", pc, pc_plus4);
        end
        mem_ack(32'h13);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({imem_if.imem_addr, pc, pc_plus4} !== {32'h0, 32'h0, 32'h4}) begin
            errors++;
            $display("FAIL pc_wrap: got addr=%h pc=%h pc4=%h exp 00000000/00000000/00000004",
                     imem_if.imem_addr, pc, pc_plus4);
        end
        mem_ack(32'h13);
    endtask

    task automatic test_misalign();
        retire(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
        mem_ack(32'h13);
        retire(1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        imem_if.imem_ack = 1'b1;
        instr_done = 1'b1;
        tick(); tick(); tick();
        imem_if.imem_ack = 1'b0;
        instr_done = 1'b0;
        checks++;
        if ({misalign, imem_if.imem_req, instr_valid, pc} !== {1'b1, 1'b0, 1'b0, 32'h40}) begin
            errors++;
            $display("FAIL trap_sticky: got mis=%b req=%b valid=%b pc=%h exp 1/0/0/00000040",
                     misalign, imem_if.imem_req, instr_valid, pc);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({misalign, pc} !== {1'b0, 32'h100}) begin
            errors++;
            $display("FAIL trap_reset: got mis=%b pc=%h exp 0/00000100", misalign, pc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack(32'h13);
`else
        checks++;
        if ({misalign, imem_if.imem_req, imem_if.imem_addr, pc} !== {1'b0, 1'b1, 32'h40, 32'h40}) begin
            errors++;
            $display("FAIL misalign_forced: got mis=%b req=%b addr=%h pc=%h exp 0/1/00000040/00000040",
                     misalign, imem_if.imem_req, imem_if.imem_addr, pc);
        end
        mem_ack(32'h13);
`endif
    endtask

    task automatic test_reset_mid_req();
        retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_if.imem_req, pc, imem_if.imem_addr, instr_valid} !== {1'b0, 32'h100, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got req=%b pc=%h addr=%h valid=%b exp 0/00000100/00000100/0",
                     imem_if.imem_req, pc, imem_if.imem_addr, instr_valid);
        end
        imem_if.imem_ack = 1'b1;
        imem_if.imem_rdata = 32'hBAD0_BAD0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({imem_if.imem_req, instr_valid, instr} !== {1'b1, 1'b0, 32'h13}) begin
            errors++;
            $display("FAIL late_ack: got req=%b valid=%b instr=%h exp 1/0/00000013",
                     imem_if.imem_req, instr_valid, instr);
        end
        imem_if.imem_ack = 1'b0;
        tick();
        checks++;
        if ({imem_if.imem_req, instr_valid, pc} !== {1'b1, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL req_after_reset: got req=%b valid=%b pc=%h exp 1/0/00000100",
                     imem_if.imem_req, instr_valid, pc);
        end
    endtask

    initial begin
        test_reset();
        test_ignored_inputs();
        test_wait_states();
        test_branch();
        test_jalr_and_wrap();
        test_misalign();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
